// File: rtl/ws2812_pixel_ser.sv
// Pixel-word serialiser feeding the WS2812 single-bit line driver.
// Takes 24-bit GRB words over valid/ready, issues one bit request per bit-done, then latches after the last pixel.
module ws2812_pixel_ser #(
  parameter logic [15:0] CNT_LATCH = 16'd60000,
  parameter int          PIX_WIDTH = 24
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 pix_valid_in,
  input  logic [PIX_WIDTH-1:0] pix_data_in,
  input  logic                 pix_last_in,
  output logic                 pix_ready_out,
  input  logic                 bit_done_in,
  output logic                 bit_rdy_out,
  output logic                 bit_data_out,
  output logic                 busy_out
);

  localparam logic [4:0] IDX_MAX = 5'(PIX_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_LATCH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SEND  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          latch_cnt_q, latch_cnt_d;
  logic [PIX_WIDTH-1:0] shift_q, shift_d;
  logic [4:0]           bit_idx_q, bit_idx_d;
  logic                 last_q, last_d;

  // State register; reset lands in LATCH so every first frame is preceded by a full latch period.
  // NOTE: sequential state uses non-blocking (<=) so all registers update together from pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_LATCH;
      latch_cnt_q <= '0;
      shift_q     <= '0;
      bit_idx_q   <= IDX_MAX;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      latch_cnt_q <= latch_cnt_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      last_q      <= last_d;
    end
  end

  // Next-state and datapath update.
  // NOTE: every signal gets a hold-value default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    latch_cnt_d = latch_cnt_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    last_d      = last_q;

    unique case (state_q)
      ST_LATCH: begin
        if (latch_cnt_q == CNT_LATCH - 16'd1) begin
          latch_cnt_d = '0;
          state_d     = ST_IDLE;
        end else begin
          latch_cnt_d = latch_cnt_q + 16'd1;
        end
      end

      ST_IDLE: begin
        // pix_ready_out is high throughout IDLE, so valid alone completes the handshake.
        if (pix_valid_in) begin
          shift_d   = pix_data_in;
          last_d    = pix_last_in;
          bit_idx_d = IDX_MAX;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (bit_done_in) begin
          // Zero check precedes the decrement, so the index never wraps.
          if (bit_idx_q != 5'd0) begin
            shift_d   = {shift_q[PIX_WIDTH-2:0], 1'b0};
            bit_idx_d = bit_idx_q - 5'd1;
            state_d   = ST_SEND;
          end else if (last_q) begin
            latch_cnt_d = '0;
            state_d     = ST_LATCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_LATCH;
      end
    endcase
  end

  // Outputs decode registered state only; the data bit stays stable through WAIT
  // because the line driver samples it a cycle after the request.
  always_comb begin
    pix_ready_out = (state_q == ST_IDLE);
    bit_rdy_out   = (state_q == ST_SEND);
    bit_data_out  = ((state_q == ST_SEND) || (state_q == ST_WAIT)) ? shift_q[PIX_WIDTH-1] : 1'b0;
    busy_out      = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_ws2812_pixel_ser.sv
// Self-checking bench for ws2812_pixel_ser: randomized pixels compared bit by bit against
// the MSB-first expansion of each word, plus latch timing, back-to-back and reset scenarios.
module tb_ws2812_pixel_ser;

  localparam int          PW    = 24;
  localparam logic [15:0] LATCH = 16'd16;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b1;
  logic          pix_valid_in = 1'b0;
  logic [PW-1:0] pix_data_in = '0;
  logic          pix_last_in = 1'b0;
  logic          pix_ready_out;
  logic          bit_done_in = 1'b0;
  logic          bit_rdy_out;
  logic          bit_data_out;
  logic          busy_out;

  int checks = 0;
  int passed = 0;

  ws2812_pixel_ser #(.CNT_LATCH(LATCH), .PIX_WIDTH(PW)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .pix_valid_in (pix_valid_in),
    .pix_data_in  (pix_data_in),
    .pix_last_in  (pix_last_in),
    .pix_ready_out(pix_ready_out),
    .bit_done_in  (bit_done_in),
    .bit_rdy_out  (bit_rdy_out),
    .bit_data_out (bit_data_out),
    .busy_out     (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Wait for ready (bounded), present one word for one edge, report whether the
  // first bit request appears in the cycle right after the accepting edge.
  task automatic send_pixel(input logic [PW-1:0] data, input logic last,
                            output bit timeout, output logic lat_rdy);
    int w;
    w = 0;
    timeout = 1'b0;
    while (pix_ready_out !== 1'b1 && w < 200) begin
      @(negedge clk_in);
      w++;
    end
    if (pix_ready_out !== 1'b1) timeout = 1'b1;
    pix_valid_in = 1'b1;
    pix_data_in  = data;
    pix_last_in  = last;
    @(negedge clk_in);
    lat_rdy      = bit_rdy_out;
    pix_valid_in = 1'b0;
    pix_data_in  = PW'($urandom);
    pix_last_in  = 1'($urandom);
  endtask

  // Line-driver model: answer each request with bit_done_in 5 cycles later and
  // gather the bits. Counts data/request glitches during the wait and the largest
  // delay between a done pulse and the following request.
  task automatic collect(input int n, output logic [PW-1:0] word, output int bad,
                         output int max_gap, output bit timeout);
    int   gap;
    logic v;
    word = '0; bad = 0; max_gap = 0; timeout = 1'b0;
    for (int b = 0; b < n; b++) begin
      gap = 0;
      while (bit_rdy_out !== 1'b1 && gap < 200) begin
        @(negedge clk_in);
        gap++;
      end
      if (bit_rdy_out !== 1'b1) begin
        timeout = 1'b1;
        return;
      end
      if (b > 0 && gap > max_gap) max_gap = gap;
      v = bit_data_out;
      word = {word[PW-2:0], v};
      for (int c = 0; c < 4; c++) begin
        @(negedge clk_in);
        if (bit_rdy_out !== 1'b0 || bit_data_out !== v || busy_out !== 1'b1) bad++;
      end
      bit_done_in = 1'b1;
      @(negedge clk_in);
      bit_done_in = 1'b0;
    end
  endtask

  // Count cycles until ready, optionally firing random spurious bit_done_in pulses.
  task automatic measure_latch(input bit noise, output int n, output int rdy_seen);
    n = 0; rdy_seen = 0;
    while (pix_ready_out !== 1'b1 && n < 1000) begin
      if (bit_rdy_out !== 1'b0 || bit_data_out !== 1'b0 || busy_out !== 1'b1) rdy_seen++;
      bit_done_in = noise ? 1'($urandom) : 1'b0;
      @(negedge clk_in);
      n++;
    end
    bit_done_in = 1'b0;
  endtask

  task automatic test_reset();
    int n, bad;
    #1 rst_n_in = 1'b0;
    #1;
    if ({pix_ready_out, bit_rdy_out, bit_data_out, busy_out} !== 4'b0001)
      $display("FAIL reset_outputs: got %b want 0001", {pix_ready_out, bit_rdy_out, bit_data_out, busy_out});
    else passed++;
    checks++;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    measure_latch(1'b0, n, bad);
    if (n !== int'(LATCH)) $display("FAIL reset_latch_len: got %0d want %0d", n, LATCH);
    else passed++;
    checks++;
    if (bad !== 0) $display("FAIL reset_latch_quiet: got %0d glitches want 0", bad);
    else passed++;
    checks++;
    if (busy_out !== 1'b0 || bit_data_out !== 1'b0)
      $display("FAIL idle_outputs: got busy=%b data=%b want 0 0", busy_out, bit_data_out);
    else passed++;
    checks++;
  endtask

  task automatic test_single_pixel();
    bit to; logic lat; logic [PW-1:0] w; int bad, gap, n, q;
    send_pixel(24'hA50F81, 1'b1, to, lat);
    if (to || lat !== 1'b1) $display("FAIL single_latency: got to=%0d rdy=%b want 0 1", to, lat);
    else passed++;
    checks++;
    collect(PW, w, bad, gap, to);
    if (to || w !== 24'hA50F81) $display("FAIL single_bits: got %h to=%0d want a50f81", w, to);
    else passed++;
    checks++;
    if (bad !== 0) $display("FAIL single_stable: got %0d glitches want 0", bad);
    else passed++;
    checks++;
    if (gap !== 0) $display("FAIL single_gap: got %0d want 0", gap);
    else passed++;
    checks++;
    measure_latch(1'b0, n, q);
    if (n !== int'(LATCH) || q !== 0) $display("FAIL single_latch: got %0d/%0d want %0d/0", n, q, LATCH);
    else passed++;
    checks++;
  endtask

  task automatic test_back_to_back();
    bit to; logic [PW-1:0] w; int bad, gap, n, q;
    pix_valid_in = 1'b1;
    pix_data_in  = 24'hFFFFFF;
    pix_last_in  = 1'b0;
    @(negedge clk_in);
    pix_data_in = 24'h000000;
    pix_last_in = 1'b1;
    collect(PW, w, bad, gap, to);
    if (to || w !== 24'hFFFFFF || bad !== 0)
      $display("FAIL b2b_first: got %h bad=%0d to=%0d want ffffff 0 0", w, bad, to);
    else passed++;
    checks++;
    if (pix_ready_out !== 1'b1) $display("FAIL b2b_ready: got %b want 1", pix_ready_out);
    else passed++;
    checks++;
    @(negedge clk_in);
    pix_valid_in = 1'b0;
    if (bit_rdy_out !== 1'b1) $display("FAIL b2b_no_gap: got %b want 1", bit_rdy_out);
    else passed++;
    checks++;
    collect(PW, w, bad, gap, to);
    if (to || w !== 24'h000000 || bad !== 0)
      $display("FAIL b2b_second: got %h bad=%0d to=%0d want 000000 0 0", w, bad, to);
    else passed++;
    checks++;
    measure_latch(1'b0, n, q);
    if (n !== int'(LATCH)) $display("FAIL b2b_latch: got %0d want %0d", n, LATCH);
    else passed++;
    checks++;
  endtask

  task automatic test_spurious_done();
    bit to; logic lat; logic [PW-1:0] w; logic [PW-1:0] px; int bad, gap, n, q, ib;
    ib = 0;
    for (int c = 0; c < 6; c++) begin
      bit_done_in = 1'b1;
      @(negedge clk_in);
      if (pix_ready_out !== 1'b1 || bit_rdy_out !== 1'b0 || busy_out !== 1'b0) ib++;
    end
    bit_done_in = 1'b0;
    if (ib !== 0) $display("FAIL spurious_idle: got %0d disturbances want 0", ib);
    else passed++;
    checks++;
    px = PW'($urandom);
    send_pixel(px, 1'b1, to, lat);
    collect(PW, w, bad, gap, to);
    if (to || w !== px) $display("FAIL spurious_pixel: got %h want %h", w, px);
    else passed++;
    checks++;
    measure_latch(1'b1, n, q);
    if (n !== int'(LATCH) || q !== 0)
      $display("FAIL spurious_latch: got len=%0d glitches=%0d want %0d 0", n, q, LATCH);
    else passed++;
    checks++;
  endtask

  task automatic test_random_pixels();
    bit to; logic lat; logic [PW-1:0] w, px; logic last; int bad, gap, n, q;
    for (int p = 0; p < 8; p++) begin
      px   = PW'($urandom);
      last = (p == 7) ? 1'b1 : 1'($urandom);
      send_pixel(px, last, to, lat);
      collect(PW, w, bad, gap, to);
      // Expected stream is the word read out MSB first: reassembling it must reproduce px.
      if (to || lat !== 1'b1 || w !== px || bad !== 0 || gap !== 0)
        $display("FAIL random_pixel%0d: got %h lat=%b bad=%0d gap=%0d want %h 1 0 0", p, w, lat, bad, gap, px);
      else passed++;
      checks++;
      if (last) begin
        measure_latch(1'b0, n, q);
        if (n !== int'(LATCH)) $display("FAIL random_latch%0d: got %0d want %0d", p, n, LATCH);
        else passed++;
        checks++;
      end else begin
        if (pix_ready_out !== 1'b1) $display("FAIL random_ready%0d: got %b want 1", p, pix_ready_out);
        else passed++;
        checks++;
      end
    end
  endtask

  task automatic test_reset_mid_pixel();
    bit to; logic lat; logic [PW-1:0] w, px; int bad, gap, n, q;
    px = PW'($urandom);
    send_pixel(px, 1'b0, to, lat);
    collect(10, w, bad, gap, to);
    if (to || w[9:0] !== px[PW-1:PW-10]) $display("FAIL mid_prefix: got %h want %h", w[9:0], px[PW-1:PW-10]);
    else passed++;
    checks++;
    rst_n_in = 1'b0;
    #1;
    if ({pix_ready_out, bit_rdy_out, bit_data_out, busy_out} !== 4'b0001)
      $display("FAIL mid_reset_outputs: got %b want 0001", {pix_ready_out, bit_rdy_out, bit_data_out, busy_out});
    else passed++;
    checks++;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    measure_latch(1'b0, n, q);
    if (n !== int'(LATCH) || q !== 0) $display("FAIL mid_latch: got %0d/%0d want %0d/0", n, q, LATCH);
    else passed++;
    checks++;
    px = PW'($urandom);
    send_pixel(px, 1'b1, to, lat);
    collect(PW, w, bad, gap, to);
    if (to || w !== px || bad !== 0) $display("FAIL mid_fresh: got %h bad=%0d want %h 0", w, bad, px);
    else passed++;
    checks++;
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_spurious_done();
    test_random_pixels();
    test_reset_mid_pixel();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
